execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
Execute stage of the ARM-LP datapath. It sits directly downstream of operand preparation and consumes its readData1, readData2 (already muxed by aluSRC) and pcOffsetFilled outputs. It performs single-cycle ALU operations and an iterative 32-cycle multiply, computes the branch target, and presents registered results with NZCV flags to the memory stage over a valid/ready handshake.

Parameters:
DATA_WIDTH, 32, operand/result width; the multiply iteration count equals DATA_WIDTH
REG_ADDR_WIDTH, 5, destination register address width

Ports:
clock  input  1  main clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
inValid  input  1  upstream presents an operation
inReady  output  1  stage can accept an operation this cycle
aluOp  input  4  operation select
readData1  input  DATA_WIDTH  operand A
readData2  input  DATA_WIDTH  operand B (register or immediate)
pcIn  input  DATA_WIDTH  PC of the instruction
pcOffsetFilled  input  DATA_WIDTH  sign/zero-filled word offset
destRegIn  input  REG_ADDR_WIDTH  writeback register address
regWriteIn  input  1  writeback enable
outValid  output  1  result registers hold a valid result
outReady  input  1  downstream accepts the result
aluResult  output  DATA_WIDTH  result
flags  output  4  {N,Z,C,V}
branchTarget  output  DATA_WIDTH  pcIn + (pcOffsetFilled << 2)
destRegOut  output  REG_ADDR_WIDTH  registered destRegIn
regWriteOut  output  1  registered regWriteIn

Behaviour:
- Reset (synchronous, active-high): all outputs 0, state IDLE, multiply counter 0, outValid=0. Reset during MUL_BUSY aborts the multiply; no result is produced.
- Opcodes: 0000 AND, 0001 ORR, 0010 ADD, 0011 LSL (A << B[4:0]), 0100 LSR (logical, A >> B[4:0]), 0110 SUB (A-B), 0111 PASSB, 1000 MUL (low 32 bits of A*B, unsigned), 1100 NOR. Any other code gives result 0 and flags 0000; the operation is still accepted and still returns outValid.
- Flags: N=result[31], Z=(result==0) for all ops. For ADD, C=carry out of bit 31 and V=signed overflow. For SUB, C=1 when A>=B unsigned (no borrow) and V=signed overflow. C=V=0 for all other ops.
- inReady = (state==IDLE) && (!outValid || outReady).
- Accept = inValid && inReady. On accept, destRegIn, regWriteIn and branchTarget are captured. branchTarget wraps mod 2^32.
- States:
  - IDLE: accepting a non-MUL op loads the output registers on the next edge with outValid=1 (latency 1 cycle). Accepting a MUL op moves to MUL_BUSY and latches A, B and the counter.
  - MUL_BUSY: one shift-add iteration per cycle. inReady=0. After DATA_WIDTH iterations the result and flags are written, outValid=1, and the state returns to IDLE. Latency from accept to outValid is DATA_WIDTH+1 = 33 cycles. The output registers are guaranteed free because the MUL could only be accepted when they were free or draining.
- Output hold: while outValid && !outReady, all outputs stay stable.
- outValid clears on (outValid && outReady) unless a new result loads in the same edge. Back-to-back single-cycle ops at full throughput are allowed when outReady=1.
- Simultaneous accept and drain in the same cycle: the new result replaces the old one, and outValid stays 1.

Decomposition:
- Shared package arm_lp_pkg: aluOp code constants, flag bit indices, DATA_WIDTH/REG_ADDR_WIDTH defaults, state encoding (IDLE, MUL_BUSY).
- Sub-module: iter_multiplier. Start/busy/done interface, 32-iteration shift-add, instantiated once. All other logic stays in execute_stage.

Test Plan:
- ADD 0x7FFFFFFF+1 with outReady=1 -> one cycle later aluResult=0x80000000, flags N=1 Z=0 C=0 V=1, outValid=1 for exactly 1 cycle.
- SUB 5-5 then SUB 3-5 back-to-back -> results 0 (flags 0110: Z=1, C=1) then 0xFFFFFFFE (flags 1000: N=1); inReady held 1 throughout.
- MUL 0x00010001*0x00010001 -> inReady=0 for 32 cycles, result 0x00020001 (low word) 33 cycles after accept, flags 0000.
- Backpressure: outReady=0 after an ORR result -> outputs frozen, inReady=0. A new AND presented meanwhile is accepted only in the cycle outReady=1, and its result appears on the next edge.
- Reset asserted at MUL iteration 10 -> next edge all outputs 0, outValid=0, inReady=1. A following ADD 2+3 yields 5 with no stale MUL result.
- Branch target: pcIn=0xFFFFFFF0, pcOffsetFilled=0x00000008 -> branchTarget=0x00000010 (wrap). Unknown aluOp 1111 -> aluResult=0, flags 0000, outValid=1.

Source files
------------

// File: rtl/arm_lp_pkg.sv
// rtl/arm_lp_pkg.sv - shared constants and types for the ARM-LP execute datapath
// Provides default widths, aluOp codes, NZCV flag bit positions and the
// execute-stage state encoding. No ports.
package arm_lp_pkg;

   localparam int DEF_DATA_WIDTH     = 32;
   localparam int DEF_REG_ADDR_WIDTH = 5;

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_ORR   = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_LSL   = 4'b0011;
   localparam logic [3:0] ALU_LSR   = 4'b0100;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_PASSB = 4'b0111;
   localparam logic [3:0] ALU_MUL   = 4'b1000;
   localparam logic [3:0] ALU_NOR   = 4'b1100;

   // Bit positions inside the 4-bit {N,Z,C,V} flags word
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic {
      IDLE     = 1'b0,
      MUL_BUSY = 1'b1
   } exec_state_t;

endpackage

// File: rtl/iter_multiplier.sv
// rtl/iter_multiplier.sv - iterative unsigned shift-add multiplier, one bit per cycle
// Ports:
//   clock, reset          clock and synchronous active-high reset
//   start                 latch multiplicand/multiplier when not busy
//   multiplicand/multiplier  operands (DATA_WIDTH bits)
//   busy                  iterations in progress
//   done                  high during the final iteration cycle; product valid then
//   product               low DATA_WIDTH bits of the product (valid with done)
module iter_multiplier
   import arm_lp_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] multiplicand,
   input  logic [DATA_WIDTH-1:0] multiplier,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] product
);

   localparam int CNT_W = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_WIDTH - 1);

   logic [DATA_WIDTH-1:0] acc;
   logic [DATA_WIDTH-1:0] a_reg;
   logic [DATA_WIDTH-1:0] b_reg;
   logic [CNT_W-1:0]      count;
   logic [DATA_WIDTH-1:0] partial;
   logic [DATA_WIDTH-1:0] acc_sum;

   assign partial = b_reg[0] ? a_reg : '0;
   assign acc_sum = acc + partial;

   // The last iteration's sum is handed out combinationally so the consumer
   // can register it on the same edge that retires the iteration.
   assign done    = busy && (count == LAST_ITER);
   assign product = acc_sum;

   always_ff @(posedge clock) begin
      if (reset) begin
         acc   <= '0;
         a_reg <= '0;
         b_reg <= '0;
         count <= '0;
         busy  <= 1'b0;
      end else if (start && !busy) begin
         acc   <= '0;
         a_reg <= multiplicand;
         b_reg <= multiplier;
         count <= '0;
         busy  <= 1'b1;
      end else if (busy) begin
         acc   <= acc_sum;
         a_reg <= a_reg << 1;
         b_reg <= b_reg >> 1;
         count <= count + 1'b1;
         if (done) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - ARM-LP execute stage: ALU, iterative MUL, branch target, registered outputs
// Ports:
//   clock, reset                     clock and synchronous active-high reset
//   inValid/inReady                  upstream handshake
//   aluOp, readData1, readData2      operation and operands
//   pcIn, pcOffsetFilled             branch target inputs
//   destRegIn, regWriteIn            writeback control, captured on accept
//   outValid/outReady                downstream handshake
//   aluResult, flags                 registered result and {N,Z,C,V}
//   branchTarget, destRegOut, regWriteOut  registered side-band outputs
module execute_stage
   import arm_lp_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      inValid,
   output logic                      inReady,
   input  logic [3:0]                aluOp,
   input  logic [DATA_WIDTH-1:0]     readData1,
   input  logic [DATA_WIDTH-1:0]     readData2,
   input  logic [DATA_WIDTH-1:0]     pcIn,
   input  logic [DATA_WIDTH-1:0]     pcOffsetFilled,
   input  logic [REG_ADDR_WIDTH-1:0] destRegIn,
   input  logic                      regWriteIn,
   output logic                      outValid,
   input  logic                      outReady,
   output logic [DATA_WIDTH-1:0]     aluResult,
   output logic [3:0]                flags,
   output logic [DATA_WIDTH-1:0]     branchTarget,
   output logic [REG_ADDR_WIDTH-1:0] destRegOut,
   output logic                      regWriteOut
);

   localparam int SH_W = $clog2(DATA_WIDTH);
   localparam int MSB  = DATA_WIDTH - 1;

   exec_state_t state;
   exec_state_t state_next;

   logic                  accept;
   logic                  is_mul;
   logic                  load_alu;
   logic                  mul_busy;
   logic                  mul_done;
   logic [DATA_WIDTH-1:0] mul_product;
   logic [3:0]            mul_flags;

   logic [DATA_WIDTH:0]   add_full;
   logic [DATA_WIDTH:0]   sub_full;
   logic [SH_W-1:0]       shamt;
   logic [DATA_WIDTH-1:0] alu_res;
   logic                  alu_c;
   logic                  alu_v;
   logic                  alu_known;
   logic [3:0]            alu_flags;

   assign inReady  = (state == IDLE) && !mul_busy && (!outValid || outReady);
   assign accept   = inValid && inReady;
   assign is_mul   = (aluOp == ALU_MUL);
   assign load_alu = accept && !is_mul;

   assign add_full = {1'b0, readData1} + {1'b0, readData2};
   assign sub_full = {1'b0, readData1} - {1'b0, readData2};
   assign shamt    = readData2[SH_W-1:0];

   always_comb begin
      alu_res   = '0;
      alu_c     = 1'b0;
      alu_v     = 1'b0;
      alu_known = 1'b1;
      case (aluOp)
         ALU_AND:   alu_res = readData1 & readData2;
         ALU_ORR:   alu_res = readData1 | readData2;
         ALU_ADD: begin
            alu_res = add_full[MSB:0];
            alu_c   = add_full[DATA_WIDTH];
            alu_v   = (readData1[MSB] == readData2[MSB]) && (alu_res[MSB] != readData1[MSB]);
         end
         ALU_LSL:   alu_res = readData1 << shamt;
         ALU_LSR:   alu_res = readData1 >> shamt;
         ALU_SUB: begin
            alu_res = sub_full[MSB:0];
            // No borrow out of the top bit means A >= B unsigned
            alu_c   = !sub_full[DATA_WIDTH];
            alu_v   = (readData1[MSB] != readData2[MSB]) && (alu_res[MSB] != readData1[MSB]);
         end
         ALU_PASSB: alu_res = readData2;
         ALU_NOR:   alu_res = ~(readData1 | readData2);
         default:   alu_known = 1'b0;
      endcase
   end

   // Unknown opcodes report all-zero flags, including Z
   assign alu_flags = alu_known ? {alu_res[MSB], (alu_res == '0), alu_c, alu_v} : 4'b0000;
   assign mul_flags = {mul_product[MSB], (mul_product == '0), 1'b0, 1'b0};

   iter_multiplier #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_mul (
      .clock       (clock),
      .reset       (reset),
      .start       (accept && is_mul),
      .multiplicand(readData1),
      .multiplier  (readData2),
      .busy        (mul_busy),
      .done        (mul_done),
      .product     (mul_product)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (accept && is_mul) state_next = MUL_BUSY;
         MUL_BUSY: if (mul_done)         state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   // A MUL is only accepted when the output registers are empty or draining,
   // so the product can always be written when the multiplier finishes.
   always_ff @(posedge clock) begin
      if (reset) begin
         outValid     <= 1'b0;
         aluResult    <= '0;
         flags        <= 4'b0000;
         branchTarget <= '0;
         destRegOut   <= '0;
         regWriteOut  <= 1'b0;
      end else begin
         if (load_alu) begin
            aluResult <= alu_res;
            flags     <= alu_flags;
         end else if (mul_done) begin
            aluResult <= mul_product;
            flags     <= mul_flags;
         end
         if (accept) begin
            destRegOut   <= destRegIn;
            regWriteOut  <= regWriteIn;
            branchTarget <= pcIn + (pcOffsetFilled << 2);
         end
         if (load_alu || mul_done) begin
            outValid <= 1'b1;
         end else if (outReady) begin
            outValid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - self-checking bench for execute_stage
module tb_execute_stage;

   logic        clock;
   logic        reset;
   logic        inValid;
   logic        inReady;
   logic [3:0]  aluOp;
   logic [31:0] readData1;
   logic [31:0] readData2;
   logic [31:0] pcIn;
   logic [31:0] pcOffsetFilled;
   logic [4:0]  destRegIn;
   logic        regWriteIn;
   logic        outValid;
   logic        outReady;
   logic [31:0] aluResult;
   logic [3:0]  flags;
   logic [31:0] branchTarget;
   logic [4:0]  destRegOut;
   logic        regWriteOut;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] r;
      logic [3:0]  f;
      logic [31:0] bt;
      logic [4:0]  d;
      logic        w;
   } exp_t;

   exp_t q[$];

   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   execute_stage dut (
      .clock         (clock),
      .reset         (reset),
      .inValid       (inValid),
      .inReady       (inReady),
      .aluOp         (aluOp),
      .readData1     (readData1),
      .readData2     (readData2),
      .pcIn          (pcIn),
      .pcOffsetFilled(pcOffsetFilled),
      .destRegIn     (destRegIn),
      .regWriteIn    (regWriteIn),
      .outValid      (outValid),
      .outReady      (outReady),
      .aluResult     (aluResult),
      .flags         (flags),
      .branchTarget  (branchTarget),
      .destRegOut    (destRegOut),
      .regWriteOut   (regWriteOut)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Reference ALU computed with wide integer arithmetic
   function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic [3:0] f);
      logic c;
      logic v;
      logic known;
      longint s;
      logic [63:0] wide;
      logic [4:0] sh;
      c = 1'b0;
      v = 1'b0;
      known = 1'b1;
      r = 32'h0;
      sh = b[4:0];
      case (op)
         4'b0000: r = a & b;
         4'b0001: r = a | b;
         4'b0010: begin
            wide = {32'h0, a} + {32'h0, b};
            r = wide[31:0];
            c = (wide > 64'hFFFF_FFFF);
            s = longint'($signed(a)) + longint'($signed(b));
            v = (s > SMAX) || (s < SMIN);
         end
         4'b0011: r = a << sh;
         4'b0100: r = a >> sh;
         4'b0110: begin
            r = a - b;
            c = (a >= b);
            s = longint'($signed(a)) - longint'($signed(b));
            v = (s > SMAX) || (s < SMIN);
         end
         4'b0111: r = b;
         4'b1000: begin
            wide = {32'h0, a} * {32'h0, b};
            r = wide[31:0];
         end
         4'b1100: r = ~(a | b);
         default: known = 1'b0;
      endcase
      f = known ? {r[31], (r == 32'h0), c, v} : 4'b0000;
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      inValid = 1'b0;
      outReady = 1'b1;
      aluOp = 4'b0000;
      readData1 = 32'h0;
      readData2 = 32'h0;
      pcIn = 32'h0;
      pcOffsetFilled = 32'h0;
      destRegIn = 5'h0;
      regWriteIn = 1'b0;
      step();
      step();
      reset = 1'b0;
      #1;
      n_checks++;
      if (outValid !== 1'b0) begin n_fail++; $display("FAIL reset_outValid got=%b exp=0", outValid); end
      n_checks++;
      if (aluResult !== 32'h0 || flags !== 4'h0 || branchTarget !== 32'h0) begin
         n_fail++; $display("FAIL reset_data got=%h/%b/%h exp=0/0/0", aluResult, flags, branchTarget);
      end
      n_checks++;
      if (destRegOut !== 5'h0 || regWriteOut !== 1'b0) begin
         n_fail++; $display("FAIL reset_wb got=%h/%b exp=0/0", destRegOut, regWriteOut);
      end
      n_checks++;
      if (inReady !== 1'b1) begin n_fail++; $display("FAIL reset_inReady got=%b exp=1", inReady); end
   endtask

   task automatic test_add_overflow();
      aluOp = 4'b0010;
      readData1 = 32'h7FFF_FFFF;
      readData2 = 32'h0000_0001;
      destRegIn = 5'd7;
      regWriteIn = 1'b1;
      inValid = 1'b1;
      outReady = 1'b1;
      step();
      inValid = 1'b0;
      n_checks++;
      if (outValid !== 1'b1 || aluResult !== 32'h8000_0000 || flags !== 4'b1001) begin
         n_fail++; $display("FAIL add_overflow got=%b/%h/%b exp=1/80000000/1001", outValid, aluResult, flags);
      end
      n_checks++;
      if (destRegOut !== 5'd7 || regWriteOut !== 1'b1) begin
         n_fail++; $display("FAIL add_wb got=%h/%b exp=07/1", destRegOut, regWriteOut);
      end
      step();
      n_checks++;
      if (outValid !== 1'b0) begin n_fail++; $display("FAIL add_one_cycle got=%b exp=0", outValid); end
   endtask

   task automatic test_back_to_back();
      aluOp = 4'b0110;
      readData1 = 32'd5;
      readData2 = 32'd5;
      inValid = 1'b1;
      outReady = 1'b1;
      #1;
      n_checks++;
      if (inReady !== 1'b1) begin n_fail++; $display("FAIL b2b_ready0 got=%b exp=1", inReady); end
      step();
      n_checks++;
      if (aluResult !== 32'h0 || flags !== 4'b0110 || outValid !== 1'b1) begin
         n_fail++; $display("FAIL sub_equal got=%h/%b/%b exp=00000000/0110/1", aluResult, flags, outValid);
      end
      n_checks++;
      if (inReady !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1 got=%b exp=1", inReady); end
      readData1 = 32'd3;
      step();
      inValid = 1'b0;
      n_checks++;
      if (aluResult !== 32'hFFFF_FFFE || flags !== 4'b1000 || outValid !== 1'b1) begin
         n_fail++; $display("FAIL sub_borrow got=%h/%b/%b exp=fffffffe/1000/1", aluResult, flags, outValid);
      end
      step();
   endtask

   task automatic test_mul();
      int bad;
      aluOp = 4'b1000;
      readData1 = 32'h0001_0001;
      readData2 = 32'h0001_0001;
      inValid = 1'b1;
      outReady = 1'b1;
      step();
      inValid = 1'b0;
      bad = 0;
      for (int i = 1; i <= 32; i++) begin
         if (inReady !== 1'b0 || outValid !== 1'b0) bad++;
         step();
      end
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL mul_busy_window got=%0d bad cycles exp=0", bad); end
      n_checks++;
      if (outValid !== 1'b1 || aluResult !== 32'h0002_0001 || flags !== 4'b0000) begin
         n_fail++; $display("FAIL mul_result got=%b/%h/%b exp=1/00020001/0000", outValid, aluResult, flags);
      end
      step();
      n_checks++;
      if (outValid !== 1'b0 || inReady !== 1'b1) begin
         n_fail++; $display("FAIL mul_drain got=%b/%b exp=0/1", outValid, inReady);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] a0, b0, a1, b1, exp_orr, exp_and;
      logic [3:0]  f_orr, f_and;
      int bad;
      a0 = $urandom;
      b0 = $urandom;
      a1 = $urandom;
      b1 = $urandom;
      model(4'b0001, a0, b0, exp_orr, f_orr);
      model(4'b0000, a1, b1, exp_and, f_and);
      aluOp = 4'b0001;
      readData1 = a0;
      readData2 = b0;
      inValid = 1'b1;
      outReady = 1'b0;
      step();
      aluOp = 4'b0000;
      readData1 = a1;
      readData2 = b1;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (outValid !== 1'b1 || aluResult !== exp_orr || flags !== f_orr || inReady !== 1'b0) bad++;
         step();
      end
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL bp_hold got=%0d bad cycles exp=0 (res=%h exp=%h)", bad, aluResult, exp_orr); end
      outReady = 1'b1;
      #1;
      n_checks++;
      if (inReady !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got=%b exp=1", inReady); end
      step();
      inValid = 1'b0;
      n_checks++;
      if (outValid !== 1'b1 || aluResult !== exp_and || flags !== f_and) begin
         n_fail++; $display("FAIL bp_and got=%b/%h/%b exp=1/%h/%b", outValid, aluResult, flags, exp_and, f_and);
      end
      step();
      n_checks++;
      if (outValid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got=%b exp=0", outValid); end
   endtask

   task automatic test_reset_mid_mul();
      int stale;
      aluOp = 4'b1000;
      readData1 = $urandom;
      readData2 = $urandom;
      inValid = 1'b1;
      outReady = 1'b1;
      step();
      inValid = 1'b0;
      for (int i = 0; i < 10; i++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      n_checks++;
      if (outValid !== 1'b0 || aluResult !== 32'h0 || flags !== 4'h0 || branchTarget !== 32'h0 ||
          destRegOut !== 5'h0 || regWriteOut !== 1'b0 || inReady !== 1'b1) begin
         n_fail++; $display("FAIL mul_abort got=%b/%h/%b/%b exp=0/00000000/0000/1", outValid, aluResult, flags, inReady);
      end
      aluOp = 4'b0010;
      readData1 = 32'd2;
      readData2 = 32'd3;
      inValid = 1'b1;
      step();
      inValid = 1'b0;
      n_checks++;
      if (outValid !== 1'b1 || aluResult !== 32'd5 || flags !== 4'b0000) begin
         n_fail++; $display("FAIL add_after_abort got=%b/%h/%b exp=1/00000005/0000", outValid, aluResult, flags);
      end
      stale = 0;
      step();
      for (int i = 0; i < 35; i++) begin
         if (outValid !== 1'b0) stale++;
         step();
      end
      n_checks++;
      if (stale != 0) begin n_fail++; $display("FAIL no_stale_mul got=%0d valid cycles exp=0", stale); end
   endtask

   task automatic test_branch_unknown();
      aluOp = 4'b1111;
      readData1 = $urandom | 32'h1;
      readData2 = $urandom | 32'h1;
      pcIn = 32'hFFFF_FFF0;
      pcOffsetFilled = 32'h0000_0008;
      inValid = 1'b1;
      outReady = 1'b1;
      step();
      inValid = 1'b0;
      n_checks++;
      if (branchTarget !== 32'h0000_0010) begin
         n_fail++; $display("FAIL branch_wrap got=%h exp=00000010", branchTarget);
      end
      n_checks++;
      if (outValid !== 1'b1 || aluResult !== 32'h0 || flags !== 4'b0000) begin
         n_fail++; $display("FAIL unknown_op got=%b/%h/%b exp=1/00000000/0000", outValid, aluResult, flags);
      end
      step();
   endtask

   task automatic drain_check();
      exp_t e;
      if (outValid && outReady) begin
         n_checks++;
         if (q.size() == 0) begin
            n_fail++; $display("FAIL rand_unexpected got=result %h exp=none", aluResult);
         end else begin
            e = q.pop_front();
            if (aluResult !== e.r || flags !== e.f || branchTarget !== e.bt || destRegOut !== e.d || regWriteOut !== e.w) begin
               n_fail++;
               $display("FAIL rand_result got=%h/%b/%h/%h/%b exp=%h/%b/%h/%h/%b",
                        aluResult, flags, branchTarget, destRegOut, regWriteOut, e.r, e.f, e.bt, e.d, e.w);
            end
         end
      end
   endtask

   task automatic test_random();
      exp_t e;
      int   budget;
      for (int cyc = 0; cyc < 600; cyc++) begin
         inValid = ($urandom_range(0, 3) != 0);
         aluOp = 4'($urandom_range(0, 15));
         if (aluOp == 4'b1000 && $urandom_range(0, 3) != 0) aluOp = 4'b0010;
         readData1 = $urandom;
         case ($urandom_range(0, 4))
            0: readData2 = 32'h0;
            1: readData2 = 32'h8000_0000;
            2: readData2 = readData1;
            default: readData2 = $urandom;
         endcase
         pcIn = $urandom;
         pcOffsetFilled = $urandom;
         destRegIn = 5'($urandom);
         regWriteIn = 1'($urandom);
         outReady = ($urandom_range(0, 3) != 0);
         #1;
         drain_check();
         if (inValid && inReady) begin
            model(aluOp, readData1, readData2, e.r, e.f);
            e.bt = pcIn + (pcOffsetFilled << 2);
            e.d = destRegIn;
            e.w = regWriteIn;
            q.push_back(e);
         end
         step();
      end
      inValid = 1'b0;
      outReady = 1'b1;
      budget = 0;
      while ((q.size() != 0 || outValid) && budget < 100) begin
         #1;
         drain_check();
         step();
         budget++;
      end
      n_checks++;
      if (q.size() != 0) begin n_fail++; $display("FAIL rand_leftover got=%0d pending exp=0", q.size()); end
   endtask

   initial begin
      test_reset();
      test_add_overflow();
      test_back_to_back();
      test_mul();
      test_backpressure();
      test_reset_mid_mul();
      test_branch_unknown();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
